// File: rtl/x25519_pkg.sv
// Shared definitions for the X25519 arithmetic engines and their known-answer-test runner.
//   P25519      : field prime 2^255 - 19
//   kat_state_t : sequencer states of kat_runner
//   clog2       : ceiling log2 usable in parameter expressions
package x25519_pkg;

  localparam logic [254:0] P25519 = {255{1'b1}} - 255'd18;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StCheck,
    StNext,
    StDone
  } kat_state_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return r;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the pass/fail/loop tallies.
//   i_clk : clock
//   i_rst : synchronous active-high reset (clears to 0)
//   i_inc : add one unless already at all-ones
//   i_clr : synchronous clear, wins over i_inc
//   o_q   : current count
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_q
);

  logic [CNT_W-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_q <= '0;
    end else if (i_inc && (r_q != {CNT_W{1'b1}})) begin
      r_q <= r_q + CNT_W'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/kat_runner.sv
// Known-answer-test sequencer for req/res handshaked arithmetic engines. Walks NVEC
// operand/expected pairs from an external combinational ROM, issues each operand, compares the
// result and keeps saturating pass/fail/loop tallies, first-failure capture and a watchdog.
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : start pulse (IDLE, or DONE without timeout)
//   i_loop_en           : wrap to vector 0 after the last one
//   o_vec_idx           : ROM address; i_vec_k / i_vec_exp are the ROM data at that address
//   o_eng_k, o_eng_req_valid, i_eng_req_ready : request channel to the engine
//   i_eng_res, i_eng_res_valid, o_eng_res_ready : result channel from the engine
//   o_pass_cnt, o_fail_cnt, o_loop_cnt : saturating tallies
//   o_fail_valid, o_fail_idx : sticky first failure
//   o_running, o_done, o_timeout_err : status
module kat_runner
  import x25519_pkg::*;
#(
  parameter int unsigned W         = 255,
  parameter int unsigned NVEC      = 4,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned TMO       = 1 << 24,
  parameter int unsigned AUTOSTART = 1,
  localparam int unsigned IW = (clog2(NVEC) > 1) ? clog2(NVEC) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic             i_loop_en,
  output logic [IW-1:0]    o_vec_idx,
  input  logic [W-1:0]     i_vec_k,
  input  logic [W-1:0]     i_vec_exp,
  output logic [W-1:0]     o_eng_k,
  output logic             o_eng_req_valid,
  input  logic             i_eng_req_ready,
  input  logic [W-1:0]     i_eng_res,
  input  logic             i_eng_res_valid,
  output logic             o_eng_res_ready,
  output logic [CNT_W-1:0] o_pass_cnt,
  output logic [CNT_W-1:0] o_fail_cnt,
  output logic [CNT_W-1:0] o_loop_cnt,
  output logic             o_fail_valid,
  output logic [IW-1:0]    o_fail_idx,
  output logic             o_running,
  output logic             o_done,
  output logic             o_timeout_err
);

  localparam int unsigned   TW      = (clog2(TMO) > 1) ? clog2(TMO) : 1;
  localparam logic [IW-1:0] LastIdx = IW'(NVEC - 1);
  localparam logic [TW-1:0] TmoLast = TW'(TMO - 1);

  kat_state_t    r_state;
  logic [IW-1:0] r_idx;
  logic          r_req_valid;
  logic [W-1:0]  r_res;
  logic [TW-1:0] r_timer;
  logic          r_first;      // high only on the first cycle out of reset
  logic          r_fail_valid;
  logic [IW-1:0] r_fail_idx;
  logic          r_timeout;

  logic w_res_eq;
  logic w_tmo;
  logic w_clr;
  logic w_pass_inc;
  logic w_fail_inc;
  logic w_loop_inc;

  assign w_res_eq = (r_res == i_vec_exp);
  // A result arriving on the expiry cycle takes priority over the timeout.
  assign w_tmo    = (r_state == StWait) && !i_eng_res_valid && (r_timer == TmoLast);
  assign w_clr    = (r_state == StDone) && i_start && !r_timeout;

  assign w_pass_inc = (r_state == StCheck) && w_res_eq;
  assign w_fail_inc = ((r_state == StCheck) && !w_res_eq) || w_tmo;
  assign w_loop_inc = (r_state == StNext) && (r_idx == LastIdx);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_idx        <= '0;
      r_req_valid  <= 1'b0;
      r_res        <= '0;
      r_timer      <= '0;
      r_first      <= 1'b1;
      r_fail_valid <= 1'b0;
      r_fail_idx   <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_first <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start || ((AUTOSTART != 0) && r_first)) begin
            r_state     <= StIssue;
            r_req_valid <= 1'b1;
          end
        end
        StIssue: begin
          if (i_eng_req_ready) begin
            r_state     <= StWait;
            r_req_valid <= 1'b0;
            r_timer     <= '0;
          end
        end
        StWait: begin
          if (i_eng_res_valid) begin
            r_res   <= i_eng_res;
            r_state <= StCheck;
          end else if (w_tmo) begin
            r_timeout <= 1'b1;
            r_state   <= StDone;
            if (!r_fail_valid) begin
              r_fail_valid <= 1'b1;
              r_fail_idx   <= r_idx;
            end
          end else begin
            r_timer <= r_timer + TW'(1);
          end
        end
        StCheck: begin
          if (!w_res_eq && !r_fail_valid) begin
            r_fail_valid <= 1'b1;
            r_fail_idx   <= r_idx;
          end
          r_state <= StNext;
        end
        StNext: begin
          if (r_idx == LastIdx) begin
            if (i_loop_en) begin
              r_idx       <= '0;
              r_state     <= StIssue;
              r_req_valid <= 1'b1;
            end else begin
              r_state <= StDone;
            end
          end else begin
            r_idx       <= r_idx + IW'(1);
            r_state     <= StIssue;
            r_req_valid <= 1'b1;
          end
        end
        StDone: begin
          if (w_clr) begin
            r_fail_valid <= 1'b0;
            r_fail_idx   <= '0;
            r_idx        <= '0;
            r_state      <= StIssue;
            r_req_valid  <= 1'b1;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_req_valid <= 1'b0;
        end
      endcase
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_pass_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_inc(w_pass_inc),
    .i_clr(w_clr),
    .o_q  (o_pass_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_fail_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_inc(w_fail_inc),
    .i_clr(w_clr),
    .o_q  (o_fail_cnt)
  );

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_loop_cnt (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_inc(w_loop_inc),
    .i_clr(w_clr),
    .o_q  (o_loop_cnt)
  );

  // Operand is gated so the request bus reads zero outside ISSUE.
  assign o_eng_k         = (r_state == StIssue) ? i_vec_k : '0;
  assign o_eng_req_valid = r_req_valid;
  assign o_eng_res_ready = (r_state == StWait) && i_eng_res_valid;
  assign o_vec_idx       = r_idx;
  assign o_fail_valid    = r_fail_valid;
  assign o_fail_idx      = r_fail_idx;
  assign o_timeout_err   = r_timeout;
  assign o_running       = (r_state == StIssue) || (r_state == StWait) ||
                           (r_state == StCheck) || (r_state == StNext);
  assign o_done          = (r_state == StDone);

endmodule

// File: tb/tb_kat_runner.sv
module tb_kat_runner;

  localparam int NV = 3;
  localparam int MAXC = 3;  // 2-bit counters saturate here

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       loop_en = 1'b0;
  logic [1:0] vec_idx;
  logic [7:0] vec_k, vec_exp, eng_k;
  logic       eng_req_valid;
  logic       eng_req_ready = 1'b0;
  logic [7:0] eng_res = 8'h00;
  logic       eng_res_valid = 1'b0;
  logic       eng_res_ready;
  logic [1:0] pass_cnt, fail_cnt, loop_cnt, fail_idx;
  logic       fail_valid, running, done, timeout_err;

  logic [7:0] rom_k[NV];
  logic [7:0] rom_exp[NV];

  int checks = 0;
  int failures = 0;

  // engine knobs
  int eng_lat = 3;
  bit never_ret = 1'b0;
  int stall_left = 0;

  // monitor state
  bit chk_en = 1'b1;
  int hs_cnt = 0;
  int rr_pulses = 0;
  int stall_cyc = 0;
  bit wrap_seen = 1'b0;

  assign vec_k   = (vec_idx < 2'd3) ? rom_k[vec_idx] : 8'h00;
  assign vec_exp = (vec_idx < 2'd3) ? rom_exp[vec_idx] : 8'h00;

  always #5 clk = ~clk;

  kat_runner #(
    .W(8), .NVEC(3), .CNT_W(2), .TMO(16), .AUTOSTART(1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_start(start),
    .i_loop_en(loop_en),
    .o_vec_idx(vec_idx),
    .i_vec_k(vec_k),
    .i_vec_exp(vec_exp),
    .o_eng_k(eng_k),
    .o_eng_req_valid(eng_req_valid),
    .i_eng_req_ready(eng_req_ready),
    .i_eng_res(eng_res),
    .i_eng_res_valid(eng_res_valid),
    .o_eng_res_ready(eng_res_ready),
    .o_pass_cnt(pass_cnt),
    .o_fail_cnt(fail_cnt),
    .o_loop_cnt(loop_cnt),
    .o_fail_valid(fail_valid),
    .o_fail_idx(fail_idx),
    .o_running(running),
    .o_done(done),
    .o_timeout_err(timeout_err)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic int sat_inc(input int x);
    return (x >= MAXC) ? MAXC : x + 1;
  endfunction

  // Mock engine z = k + 1, fixed latency, optional initial ready stall; reset by the same rst.
  initial begin
    logic s_rst, s_hs, s_rs;
    logic [7:0] s_k, pend;
    bit busy;
    int lat_left;
    busy = 1'b0;
    lat_left = 0;
    pend = 8'h00;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_hs  = eng_req_valid && eng_req_ready;
      s_rs  = eng_res_valid && eng_res_ready;
      s_k   = eng_k;
      @(posedge clk);
      #1;
      if (s_rst) begin
        busy = 1'b0;
        eng_res_valid = 1'b0;
      end else begin
        if (s_rs) eng_res_valid = 1'b0;
        if (s_hs) begin
          busy = 1'b1;
          lat_left = eng_lat;
          pend = s_k + 8'd1;
        end else if (busy && !never_ret) begin
          if (lat_left <= 1) begin
            eng_res_valid = 1'b1;
            eng_res = pend;
            busy = 1'b0;
          end else begin
            lat_left--;
          end
        end
      end
      eng_req_ready = !busy && !eng_res_valid && (stall_left == 0);
      if (eng_req_valid && stall_left > 0) stall_left--;
    end
  end

  // Monitor: protocol invariants plus a per-vector scoreboard of expected tallies.
  initial begin
    int m_pass, m_fail, m_loop, m_fidx, m_idx, i;
    bit m_fv, prev_stall, prev_rr, ok;
    logic [7:0] prev_k;
    logic [1:0] prev_idx;
    int pend_q[$];
    m_pass = 0; m_fail = 0; m_loop = 0; m_fidx = 0; m_idx = 0; m_fv = 0;
    prev_stall = 0; prev_rr = 0; prev_k = 0; prev_idx = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pass = 0; m_fail = 0; m_loop = 0; m_fidx = 0; m_idx = 0; m_fv = 0;
        pend_q.delete();
        prev_stall = 0;
        prev_rr = 0;
      end else begin
        chk("vec_idx_range", int'(vec_idx < 2'd3), 1);
        if (prev_stall) begin
          chk("req_valid_hold", int'(eng_req_valid), 1);
          chk("eng_k_hold", int'(eng_k), int'(prev_k));
        end
        if (eng_res_ready) begin
          chk("res_ready_single", int'(prev_rr), 0);
          chk("res_ready_with_valid", int'(eng_res_valid), 1);
          rr_pulses++;
        end
        if (eng_req_valid && !eng_req_ready) stall_cyc++;
        if (running && prev_idx == 2'd2 && vec_idx == 2'd0) wrap_seen = 1'b1;
        if (chk_en) begin
          if (eng_req_valid && eng_req_ready) begin
            chk("hs_idx", int'(vec_idx), m_idx);
            chk("hs_eng_k", int'(eng_k), int'(rom_k[m_idx]));
            chk("hs_pass", int'(pass_cnt), m_pass);
            chk("hs_fail", int'(fail_cnt), m_fail);
            chk("hs_loop", int'(loop_cnt), m_loop);
            chk("hs_fail_valid", int'(fail_valid), int'(m_fv));
            chk("hs_fail_idx", int'(fail_idx), m_fidx);
            pend_q.push_back(m_idx);
          end
          if (eng_res_valid && eng_res_ready && pend_q.size() > 0) begin
            i = pend_q.pop_front();
            chk("res_idx", int'(vec_idx), i);
            ok = (((int'(rom_k[i]) + 1) % 256) == int'(rom_exp[i]));
            if (ok) begin
              m_pass = sat_inc(m_pass);
            end else begin
              m_fail = sat_inc(m_fail);
              if (!m_fv) begin
                m_fv = 1'b1;
                m_fidx = i;
              end
            end
            if (i == NV - 1) begin
              m_loop = sat_inc(m_loop);
              m_idx = 0;
            end else begin
              m_idx = i + 1;
            end
          end
          if (done) begin
            chk("done_pass", int'(pass_cnt), m_pass);
            chk("done_fail", int'(fail_cnt), m_fail);
            chk("done_loop", int'(loop_cnt), m_loop);
            chk("done_fail_valid", int'(fail_valid), int'(m_fv));
            chk("done_fail_idx", int'(fail_idx), m_fidx);
            chk("done_vec_idx", int'(vec_idx), NV - 1);
            if (start && !timeout_err) begin
              m_pass = 0; m_fail = 0; m_loop = 0; m_fidx = 0; m_idx = 0; m_fv = 0;
            end
          end
        end
        if (eng_req_valid && eng_req_ready) hs_cnt++;
        prev_stall = eng_req_valid && !eng_req_ready;
        prev_rr = eng_res_ready;
        prev_k = eng_k;
        prev_idx = vec_idx;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string nm);
    tick();
    rst = 1'b1;
    tick();
    chk({nm, "_rst_running"}, int'(running), 0);
    chk({nm, "_rst_done"}, int'(done), 0);
    chk({nm, "_rst_req_valid"}, int'(eng_req_valid), 0);
    chk({nm, "_rst_res_ready"}, int'(eng_res_ready), 0);
    chk({nm, "_rst_eng_k"}, int'(eng_k), 0);
    chk({nm, "_rst_vec_idx"}, int'(vec_idx), 0);
    chk({nm, "_rst_counts"}, int'({pass_cnt, fail_cnt, loop_cnt}), 0);
    chk({nm, "_rst_fail"}, int'({fail_valid, fail_idx}), 0);
    chk({nm, "_rst_timeout"}, int'(timeout_err), 0);
    tick();
    rst = 1'b0;
    tick();
    chk({nm, "_autostart_valid"}, int'(eng_req_valid), 1);
    chk({nm, "_autostart_idx"}, int'(vec_idx), 0);
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max);
    int n;
    n = 0;
    while (!done && n < max) begin
      tick();
      n++;
    end
    chk({nm, "_reached_done"}, int'(done), 1);
  endtask

  task automatic set_rom_pass();
    rom_k[0] = 8'd5;   rom_exp[0] = 8'd6;
    rom_k[1] = 8'd9;   rom_exp[1] = 8'd10;
    rom_k[2] = 8'd254; rom_exp[2] = 8'd255;
  endtask

  initial begin
    int base, n, wc;
    set_rom_pass();

    // All vectors pass, single run.
    do_reset("t1");
    base = hs_cnt;
    wait_done("t1", 200);
    chk("t1_pass", int'(pass_cnt), 3);
    chk("t1_fail", int'(fail_cnt), 0);
    chk("t1_loop", int'(loop_cnt), 1);
    chk("t1_handshakes", hs_cnt - base, 3);
    chk("t1_fail_valid", int'(fail_valid), 0);
    chk("t1_running", int'(running), 0);

    // One mismatch at index 1, then a second at index 2 after a restart.
    rom_exp[1] = 8'd11;
    pulse_start();
    wait_done("t2a", 200);
    chk("t2a_pass", int'(pass_cnt), 2);
    chk("t2a_fail", int'(fail_cnt), 1);
    chk("t2a_fail_valid", int'(fail_valid), 1);
    chk("t2a_fail_idx", int'(fail_idx), 1);
    rom_exp[2] = 8'd0;
    pulse_start();
    wait_done("t2b", 200);
    chk("t2b_pass", int'(pass_cnt), 1);
    chk("t2b_fail", int'(fail_cnt), 2);
    chk("t2b_fail_idx", int'(fail_idx), 1);

    // Continuous loop with saturation, then leave loop mode mid-pass.
    set_rom_pass();
    loop_en = 1'b1;
    wrap_seen = 1'b0;
    pulse_start();
    n = 0;
    while (loop_cnt != 2'd3 && n < 400) begin
      tick();
      n++;
    end
    chk("t3_loop_reached", int'(loop_cnt), 3);
    chk("t3_pass_sat", int'(pass_cnt), 3);
    chk("t3_wrap_seen", int'(wrap_seen), 1);
    base = hs_cnt;
    n = 0;
    while (hs_cnt - base < 4 && n < 200) begin
      tick();
      n++;
    end
    chk("t3_more_hs", int'(hs_cnt - base >= 4), 1);
    chk("t3_loop_hold", int'(loop_cnt), 3);
    chk("t3_pass_hold", int'(pass_cnt), 3);
    chk("t3_running", int'(running), 1);
    n = 0;
    while (!(running && vec_idx == 2'd1) && n < 200) begin
      tick();
      n++;
    end
    loop_en = 1'b0;
    wait_done("t3", 200);
    chk("t3_end_idx", int'(vec_idx), 2);
    chk("t3_end_loop", int'(loop_cnt), 3);

    // Engine holds ready low for 7 cycles on the first request.
    stall_cyc = 0;
    rr_pulses = 0;
    stall_left = 7;
    do_reset("t4");
    wait_done("t4", 300);
    chk("t4_stall_cycles", stall_cyc, 7);
    chk("t4_res_ready_pulses", rr_pulses, 3);
    chk("t4_pass", int'(pass_cnt), 3);

    // Reset while waiting for a slow engine.
    eng_lat = 10;
    do_reset("t5a");
    base = hs_cnt;
    n = 0;
    while (hs_cnt == base && n < 50) begin
      tick();
      n++;
    end
    tick();
    tick();
    chk("t5_in_wait_running", int'(running), 1);
    chk("t5_in_wait_req", int'(eng_req_valid), 0);
    do_reset("t5b");
    base = hs_cnt;
    wait_done("t5", 400);
    chk("t5_pass", int'(pass_cnt), 3);
    chk("t5_handshakes", hs_cnt - base, 3);

    // Engine never answers: watchdog.
    chk_en = 1'b0;
    eng_lat = 3;
    never_ret = 1'b1;
    do_reset("t6");
    n = 0;
    while (n < 50) begin
      @(negedge clk);
      if (eng_req_valid && eng_req_ready) break;
      n++;
    end
    chk("t6_accepted", int'(n < 50), 1);
    wc = 0;
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (timeout_err) break;
      wc++;
      n++;
    end
    chk("t6_wait_cycles", wc, 16);
    chk("t6_timeout", int'(timeout_err), 1);
    chk("t6_done", int'(done), 1);
    chk("t6_fail", int'(fail_cnt), 1);
    chk("t6_fail_idx", int'(fail_idx), 0);
    chk("t6_fail_valid", int'(fail_valid), 1);
    chk("t6_pass", int'(pass_cnt), 0);
    pulse_start();
    repeat (5) tick();
    chk("t6_start_ignored_done", int'(done), 1);
    chk("t6_start_ignored_running", int'(running), 0);
    chk("t6_start_ignored_req", int'(eng_req_valid), 0);
    chk("t6_start_ignored_fail", int'(fail_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1, "simulation time limit");
  end

endmodule

// File: doc/kat_runner.md
Name: kat_runner

Overview:
- Parametrised known-answer-test sequencer for the req/res-handshaked arithmetic engines (scalarmultB, multmod, inv_montgomery, point_add).
- Steps through NVEC operand/expected-result pairs from an external combinational vector ROM and issues each operand to the engine.
- Compares each result and keeps saturating pass/fail/loop counters for LED/debug output.
- Adds single-run or continuous-loop mode, first-failure capture and a per-vector timeout watchdog.

Parameters:
- W, 255, operand/result width.
- NVEC, 4, number of vectors (>=1); index width IW = max(1, clog2(NVEC)).
- CNT_W, 8, width of the pass, fail and loop counters.
- TMO, 2^24, watchdog cycles allowed per vector, measured from request acceptance to result.
- AUTOSTART, 1, 1 = begin running one cycle after reset deasserts without needing a start pulse.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle start pulse; ignored while running.
- loop_en  in  1  1 = wrap to vector 0 after the last vector; sampled at each wrap.
- vec_idx  out  IW  ROM address (registered).
- vec_k  in  W  operand at vec_idx.
- vec_exp  in  W  expected result at vec_idx.
- eng_k  out  W  operand to the engine; equals vec_k.
- eng_req_valid  out  1  request valid.
- eng_req_ready  in  1  engine accepts the request.
- eng_res  in  W  engine result.
- eng_res_valid  in  1  result valid.
- eng_res_ready  out  1  result consumed.
- pass_cnt  out  CNT_W  saturating count of passing vectors.
- fail_cnt  out  CNT_W  saturating count of failing vectors.
- loop_cnt  out  CNT_W  saturating count of completed passes over all vectors.
- fail_valid  out  1  sticky; set on the first failure.
- fail_idx  out  IW  index of the first failure.
- running  out  1  high in ISSUE, WAIT, CHECK and NEXT.
- done  out  1  high in DONE.
- timeout_err  out  1  sticky; a watchdog expiry occurred.

Behaviour:
- Reset: all outputs 0, vec_idx=0, state IDLE; the timer and the result register are cleared. A reset mid-operation aborts immediately. Any handshake in flight is dropped, and the engine must be reset by the same rst.
- IDLE: if start or AUTOSTART -> ISSUE next cycle. AUTOSTART acts only on the first cycle after reset.
- ISSUE: eng_req_valid=1 and eng_k=vec_k, both held stable. On eng_req_valid & eng_req_ready -> WAIT; timer cleared.
- WAIT: eng_req_valid=0 and the timer increments each cycle.
  - On eng_res_valid: capture eng_res, drive eng_res_ready=1 for exactly this cycle -> CHECK.
  - If the timer reaches TMO-1 without a result: timeout_err=1, fail_cnt +1, and fail_idx/fail_valid are recorded if fail_valid was 0 -> DONE. Recovery from DONE after a timeout is by rst only; start is ignored.
  - If the result arrives on the same cycle the timer expires, the result wins.
- CHECK: the captured result is compared with vec_exp over the full W bits.
  - Equal: pass_cnt +1.
  - Not equal: fail_cnt +1; if fail_valid=0, set fail_valid=1 and fail_idx=vec_idx.
  - Then -> NEXT.
- NEXT:
  - If vec_idx==NVEC-1: loop_cnt +1, then either vec_idx=0 -> ISSUE if loop_en, or -> DONE otherwise. vec_idx stays NVEC-1 on the DONE path.
  - Else vec_idx +1 -> ISSUE.
  - vec_idx never exceeds NVEC-1.
- DONE: done=1.
  - start (when timeout_err=0) clears pass/fail/loop counters, fail_valid and fail_idx, sets vec_idx=0 -> ISSUE.
  - start pulses in any other state are ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Engine latency is arbitrary (>=1 cycle). The runner does not assume the engine has dropped res_valid after the consume cycle, because CHECK and NEXT each insert a cycle before the next request.
- Minimum per-vector overhead beyond engine latency: 4 cycles (ISSUE accept, WAIT consume, CHECK, NEXT).

Decomposition:
- Shared package x25519_pkg: P25519 constant, kat_state_t enum (IDLE, ISSUE, WAIT, CHECK, NEXT, DONE), clog2 helper.
- Sub-module sat_counter #(CNT_W): inc, clr, q. Instantiated three times for pass, fail and loop.
- The vector ROM stays outside the block, so a board top pairs kat_runner with a per-engine ROM.

Test Plan:
- W=8, NVEC=3, AUTOSTART=1, loop_en=0, mock engine z=k+1 with 3-cycle latency, ROM k={5,9,254}, exp={6,10,255}.
  -> pass_cnt=3, fail_cnt=0, loop_cnt=1, done=1, exactly 3 request handshakes.
- Same setup with exp[1]=11.
  -> pass_cnt=2, fail_cnt=1, fail_valid=1, fail_idx=1.
  -> A second failure injected at index 2 leaves fail_idx=1.
- loop_en=1, CNT_W=2, all vectors passing.
  -> pass_cnt saturates at 3, loop_cnt reaches 3 and holds, vec_idx wraps 2->0.
  -> Clearing loop_en mid-pass -> DONE after vector 2.
- TMO=16, mock engine never returns after accepting vector 0.
  -> timeout_err=1 on the 16th WAIT cycle, fail_cnt=1, fail_idx=0, done=1; start is then ignored.
- Mock engine holds eng_req_ready=0 for 7 cycles.
  -> eng_req_valid and eng_k stay stable; eng_res_ready is high for exactly one cycle per result.
- rst asserted during WAIT.
  -> Next cycle all outputs are 0 and the state is IDLE.
  -> With AUTOSTART=1, vector 0 is reissued one cycle after rst deasserts.
